// File: rtl/id_stage_pipe_pkg.sv
// Shared constants for the RV integer decode stage: opcodes, class one-hots,
// ALU operation codes and the registered control bundle.
package id_stage_pipe_pkg;

   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

   localparam logic [4:0] TYPE_ARITH = 5'b10000;
   localparam logic [4:0] TYPE_LOGIC = 5'b01000;
   localparam logic [4:0] TYPE_LDST  = 5'b00100;
   localparam logic [4:0] TYPE_JUMP  = 5'b00010;
   localparam logic [4:0] TYPE_SYS   = 5'b00001;

   localparam logic [7:0] ALU_ADD  = 8'h11;
   localparam logic [7:0] ALU_AND  = 8'h12;
   localparam logic [7:0] ALU_SUB  = 8'h13;
   localparam logic [7:0] ALU_OR   = 8'h14;
   localparam logic [7:0] ALU_XOR  = 8'h15;
   localparam logic [7:0] ALU_SLL  = 8'h16;
   localparam logic [7:0] ALU_SRL  = 8'h17;
   localparam logic [7:0] ALU_SRA  = 8'h18;
   localparam logic [7:0] ALU_SLT  = 8'h19;
   localparam logic [7:0] ALU_SLTU = 8'h1A;

   // Everything in the output register except the two operands.
   typedef struct packed {
      logic       illegal;
      logic       rd_w_ena;
      logic [4:0] rd_w_addr;
      logic [4:0] inst_type;
      logic [7:0] inst_opcode;
   } ctrl_t;

   // funct3 to ALU code; alt selects SUB/SRA (inst[30]).
   function automatic logic [7:0] alu_code(input logic [2:0] f3, input logic alt);
      case (f3)
         3'b000:  alu_code = alt ? ALU_SUB : ALU_ADD;
         3'b001:  alu_code = ALU_SLL;
         3'b010:  alu_code = ALU_SLT;
         3'b011:  alu_code = ALU_SLTU;
         3'b100:  alu_code = ALU_XOR;
         3'b101:  alu_code = alt ? ALU_SRA : ALU_SRL;
         3'b110:  alu_code = ALU_OR;
         default: alu_code = ALU_AND;
      endcase
   endfunction

   function automatic logic [4:0] alu_type(input logic [7:0] code);
      alu_type = (code == ALU_ADD || code == ALU_SUB || code == ALU_SLT || code == ALU_SLTU)
                 ? TYPE_ARITH : TYPE_LOGIC;
   endfunction

endpackage

// File: rtl/id_stage_pipe_if.sv
// IF -> ID -> EX handshake, regfile read ports and decoded bundle.
interface id_stage_pipe_if #(parameter int XLEN = 64, parameter int CNT_W = 16);
   logic             flush;
   logic             in_valid;
   logic             in_ready;
   logic [31:0]      in_inst;
   logic [XLEN-1:0]  in_pc;
   logic             rs1_r_ena;
   logic [4:0]       rs1_r_addr;
   logic             rs2_r_ena;
   logic [4:0]       rs2_r_addr;
   logic [XLEN-1:0]  rs1_data;
   logic [XLEN-1:0]  rs2_data;
   logic             out_valid;
   logic             out_ready;
   logic             rd_w_ena;
   logic [4:0]       rd_w_addr;
   logic [4:0]       inst_type;
   logic [7:0]       inst_opcode;
   logic [XLEN-1:0]  op1;
   logic [XLEN-1:0]  op2;
   logic             illegal;
   logic [CNT_W-1:0] illegal_cnt;

   modport slave (
      input  flush, in_valid, in_inst, in_pc, rs1_data, rs2_data, out_ready,
      output in_ready, rs1_r_ena, rs1_r_addr, rs2_r_ena, rs2_r_addr, out_valid,
             rd_w_ena, rd_w_addr, inst_type, inst_opcode, op1, op2, illegal, illegal_cnt
   );

   modport master (
      output flush, in_valid, in_inst, in_pc, rs1_data, rs2_data, out_ready,
      input  in_ready, rs1_r_ena, rs1_r_addr, rs2_r_ena, rs2_r_addr, out_valid,
             rd_w_ena, rd_w_addr, inst_type, inst_opcode, op1, op2, illegal, illegal_cnt
   );
endinterface

// File: rtl/id_decode_comb.sv
// Pure combinational decoder: instruction word, pc and register data in,
// control bundle and operands out. Illegal encodings zero everything but illegal.
module id_decode_comb
   import id_stage_pipe_pkg::*;
#(
   parameter int XLEN = 64
) (
   input  logic [31:0]     inst,
   input  logic [XLEN-1:0] pc,
   input  logic [XLEN-1:0] rs1_data,
   input  logic [XLEN-1:0] rs2_data,
   output logic            uses_rs1,
   output logic            uses_rs2,
   output ctrl_t           ctrl,
   output logic [XLEN-1:0] op1,
   output logic [XLEN-1:0] op2
);

   logic [6:0]      opc;
   logic [2:0]      f3;
   logic [6:0]      f7;
   logic [4:0]      rd;
   logic [XLEN-1:0] imm_i;
   logic [XLEN-1:0] imm_u;
   logic [XLEN-1:0] shamt;
   logic            shamt_ok;
   logic            legal;
   logic [7:0]      code;
   logic [XLEN-1:0] a;
   logic [XLEN-1:0] b;

   assign opc   = inst[6:0];
   assign f3    = inst[14:12];
   assign f7    = inst[31:25];
   assign rd    = inst[11:7];
   assign imm_i = XLEN'($signed(inst[31:20]));
   assign imm_u = XLEN'($signed({inst[31:12], 12'b0}));
   // RV64 shifts take a 6-bit amount; RV32 must keep inst[25] clear.
   assign shamt    = (XLEN == 64) ? XLEN'(inst[25:20]) : XLEN'(inst[24:20]);
   assign shamt_ok = (XLEN == 64) || !inst[25];

   // Classify by opcode, pick operands and ALU code, then validate upper bits.
   always_comb begin
      legal    = 1'b0;
      uses_rs1 = 1'b0;
      uses_rs2 = 1'b0;
      code     = ALU_ADD;
      a        = '0;
      b        = '0;
      case (opc)
         OPC_OP_IMM: begin
            uses_rs1 = 1'b1;
            a        = rs1_data;
            code     = alu_code(f3, (f3 == 3'b101) && inst[30]);
            if (f3 == 3'b001) begin
               b     = shamt;
               legal = shamt_ok && (inst[31:26] == 6'b000000);
            end else if (f3 == 3'b101) begin
               b     = shamt;
               legal = shamt_ok && (inst[31:26] == 6'b000000 || inst[31:26] == 6'b010000);
            end else begin
               b     = imm_i;
               legal = 1'b1;
            end
         end
         OPC_OP: begin
            uses_rs1 = 1'b1;
            uses_rs2 = 1'b1;
            a        = rs1_data;
            b        = rs2_data;
            code     = alu_code(f3, inst[30]);
            legal    = (f7 == 7'b0000000) ||
                       (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101));
         end
         OPC_LUI: begin
            legal = 1'b1;
            b     = imm_u;
         end
         OPC_AUIPC: begin
            legal = 1'b1;
            a     = pc;
            b     = imm_u;
         end
         default: legal = 1'b0;
      endcase
   end

   // Squash the payload of illegal instructions.
   always_comb begin
      ctrl.illegal     = !legal;
      ctrl.rd_w_ena    = legal && (rd != 5'd0);
      ctrl.rd_w_addr   = ctrl.rd_w_ena ? rd : 5'd0;
      ctrl.inst_type   = legal ? alu_type(code) : 5'd0;
      ctrl.inst_opcode = legal ? code : 8'd0;
      op1              = legal ? a : '0;
      op2              = legal ? b : '0;
   end

endmodule

// File: rtl/id_stage_pipe.sv
// Registered decode stage: valid/ready skid-free output register, regfile
// read in the accept cycle, flush, and a saturating illegal-instruction count.
module id_stage_pipe
   import id_stage_pipe_pkg::*;
#(
   parameter int XLEN  = 64,
   parameter int CNT_W = 16
) (
   input logic          clk,
   input logic          rst_n,
   id_stage_pipe_if.slave bus
);

   logic             uses_rs1;
   logic             uses_rs2;
   ctrl_t            dec_ctrl;
   logic [XLEN-1:0]  dec_op1;
   logic [XLEN-1:0]  dec_op2;
   logic             accept;

   logic             out_valid_q, out_valid_d;
   ctrl_t            ctrl_q, ctrl_d;
   logic [XLEN-1:0]  op1_q, op1_d;
   logic [XLEN-1:0]  op2_q, op2_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   id_decode_comb #(.XLEN(XLEN)) u_dec (
      .inst     (bus.in_inst),
      .pc       (bus.in_pc),
      .rs1_data (bus.rs1_data),
      .rs2_data (bus.rs2_data),
      .uses_rs1 (uses_rs1),
      .uses_rs2 (uses_rs2),
      .ctrl     (dec_ctrl),
      .op1      (dec_op1),
      .op2      (dec_op2)
   );

   assign bus.rs1_r_ena  = bus.in_valid && uses_rs1;
   assign bus.rs1_r_addr = bus.rs1_r_ena ? bus.in_inst[19:15] : 5'd0;
   assign bus.rs2_r_ena  = bus.in_valid && uses_rs2;
   assign bus.rs2_r_addr = bus.rs2_r_ena ? bus.in_inst[24:20] : 5'd0;

   assign bus.in_ready = (!out_valid_q || bus.out_ready) && !bus.flush;
   assign accept       = bus.in_valid && bus.in_ready;

   // Next state: flush drops everything, accept loads, a consumed bundle empties.
   always_comb begin
      ctrl_d = ctrl_q;
      op1_d  = op1_q;
      op2_d  = op2_q;
      cnt_d  = cnt_q;
      if (bus.flush)          out_valid_d = 1'b0;
      else if (accept)        out_valid_d = 1'b1;
      else if (bus.out_ready) out_valid_d = 1'b0;
      else                    out_valid_d = out_valid_q;
      if (accept) begin
         ctrl_d = dec_ctrl;
         op1_d  = dec_op1;
         op2_d  = dec_op2;
         if (dec_ctrl.illegal && !(&cnt_q)) cnt_d = cnt_q + 1'b1;
      end
   end

   // Output register and counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         ctrl_q      <= '0;
         op1_q       <= '0;
         op2_q       <= '0;
         cnt_q       <= '0;
      end else begin
         out_valid_q <= out_valid_d;
         ctrl_q      <= ctrl_d;
         op1_q       <= op1_d;
         op2_q       <= op2_d;
         cnt_q       <= cnt_d;
      end
   end

   assign bus.out_valid   = out_valid_q;
   assign bus.rd_w_ena    = ctrl_q.rd_w_ena;
   assign bus.rd_w_addr   = ctrl_q.rd_w_addr;
   assign bus.inst_type   = ctrl_q.inst_type;
   assign bus.inst_opcode = ctrl_q.inst_opcode;
   assign bus.illegal     = ctrl_q.illegal;
   assign bus.op1         = op1_q;
   assign bus.op2         = op2_q;
   assign bus.illegal_cnt = cnt_q;

endmodule
